// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit accumulator CPU: register/bus indices,
// opcodes, ALU selects, register-reference bits and the control-unit modes.
package cpu_pkg;

  localparam int TSTATE_W = 4;
  localparam int RR_W     = 12;

  typedef enum int {R_AR = 0, R_PC = 1, R_DR = 2, R_AC = 3, R_IR = 4, R_TR = 5} reg_idx_t;

  typedef enum int {
    B_IDLE = 0, B_AR = 1, B_PC = 2, B_DR = 3, B_AC = 4, B_IR = 5, B_TR = 6, B_MEM = 7
  } bus_src_t;

  typedef enum logic [2:0] {
    D_AND = 3'd0, D_ADD = 3'd1, D_LDA = 3'd2, D_STA = 3'd3,
    D_BUN = 3'd4, D_BSA = 3'd5, D_ISZ = 3'd6, D_REG = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS_DR = 2'd0, ALU_AND_DR = 2'd1, ALU_ADD_DR = 2'd2, ALU_CMP_AC = 2'd3
  } alu_op_t;

  typedef enum int {
    RR_HLT = 0, RR_SZA = 2, RR_SNA = 3, RR_SPA = 4, RR_INC = 5, RR_CMA = 9, RR_CLA = 11
  } rr_bit_t;

  // RUN sequences instructions; WAIT parks between single steps; HALT is terminal until reset.
  typedef enum logic [1:0] {M_RUN = 2'd0, M_WAIT = 2'd1, M_HALT = 2'd2} mode_t;

  // Index of the highest set bit of the register-reference field, -1 when empty.
  function automatic int rr_top(input logic [RR_W-1:0] f);
    int top;
    top = -1;
    for (int b = 0; b < RR_W; b++) begin
      if (f[b]) top = b;
    end
    return top;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Sequence counter: async active-low reset, synchronous clear, and hold.
module seq_counter
  import cpu_pkg::*;
#(
  parameter int W = TSTATE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         hold,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: fetch/decode/execute sequencing for the accumulator CPU.
// Optional macro CU_SINGLE_STEP_EN adds a 'step' input and a WAIT state between instructions.
module control_unit
  import cpu_pkg::*;
#(
  parameter int SC_W   = TSTATE_W,
  parameter int ADDR_W = RR_W
) (
  input  logic            clk,
  input  logic            reset,
`ifdef CU_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [15:0]     ir,
  input  logic            ac_neg,
  input  logic            ac_zero,
  input  logic            dr_zero,
  output logic [7:0]      x,
  output logic [5:0]      ld,
  output logic [5:0]      inc,
  output logic [5:0]      clr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      alu_op,
  output logic [SC_W-1:0] sc,
  output logic            halted
);

`ifdef CU_SINGLE_STEP_EN
  localparam mode_t MODE_IDLE = M_WAIT;
`else
  localparam mode_t MODE_IDLE = M_RUN;
`endif

  mode_t           mode, mode_nxt;
  logic            i_q;
  opcode_t         d_q;
  logic [SC_W-1:0] sc_q;
  logic            sc_clr, go_halt;
  logic [7:0]      x_c;
  logic [5:0]      ld_c, inc_c, clr_c;
  logic            rd_c, wr_c;
  logic [1:0]      alu_c;
  int              rr;

  seq_counter #(.W(SC_W)) u_sc (
    .clk   (clk),
    .rst_n (reset),
    .clr   (sc_clr),
    .hold  (mode != M_RUN),
    .count (sc_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode <= MODE_IDLE;
      i_q  <= 1'b0;
      d_q  <= D_AND;
    end else begin
      mode <= mode_nxt;
      if (mode == M_RUN && sc_q == SC_W'(2)) begin
        i_q <= ir[15];
        d_q <= opcode_t'(ir[14:12]);
      end
    end
  end

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end
`endif

  always_comb begin
    mode_nxt = mode;
    case (mode)
      M_RUN: begin
        if (go_halt)     mode_nxt = M_HALT;
        else if (sc_clr) mode_nxt = MODE_IDLE;
      end
      M_WAIT: begin
`ifdef CU_SINGLE_STEP_EN
        if (step && !step_q) mode_nxt = M_RUN;
`endif
      end
      M_HALT:  mode_nxt = M_HALT;
      default: mode_nxt = MODE_IDLE;
    endcase
  end

  always_comb begin
    x_c     = '0;
    ld_c    = '0;
    inc_c   = '0;
    clr_c   = '0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    alu_c   = ALU_PASS_DR;
    sc_clr  = 1'b0;
    go_halt = 1'b0;
    rr      = rr_top(ir[ADDR_W-1:0]);
    if (mode == M_RUN) begin
      case (int'(sc_q))
        0: begin x_c[B_PC] = 1'b1; ld_c[R_AR] = 1'b1; end
        1: begin
          x_c[B_MEM] = 1'b1; rd_c = 1'b1; ld_c[R_IR] = 1'b1; inc_c[R_PC] = 1'b1;
        end
        2: begin x_c[B_IR] = 1'b1; ld_c[R_AR] = 1'b1; end
        3: begin
          if (d_q == D_REG) begin
            sc_clr = 1'b1;
            // Only the highest set field bit acts; I/O (I=1) is a NOP.
            if (!i_q) begin
              case (rr)
                int'(RR_CLA): clr_c[R_AC] = 1'b1;
                int'(RR_CMA): begin alu_c = ALU_CMP_AC; ld_c[R_AC] = 1'b1; end
                int'(RR_INC): inc_c[R_AC] = 1'b1;
                int'(RR_SPA): inc_c[R_PC] = !ac_neg;
                int'(RR_SNA): inc_c[R_PC] = ac_neg;
                int'(RR_SZA): inc_c[R_PC] = ac_zero;
                int'(RR_HLT): go_halt = 1'b1;
                default: ;
              endcase
            end
          end else if (i_q) begin
            x_c[B_MEM] = 1'b1; rd_c = 1'b1; ld_c[R_AR] = 1'b1;
          end
        end
        4: begin
          case (d_q)
            D_AND, D_ADD, D_LDA, D_ISZ: begin
              x_c[B_MEM] = 1'b1; rd_c = 1'b1; ld_c[R_DR] = 1'b1;
            end
            D_STA: begin x_c[B_AC] = 1'b1; wr_c = 1'b1; sc_clr = 1'b1; end
            D_BUN: begin x_c[B_AR] = 1'b1; ld_c[R_PC] = 1'b1; sc_clr = 1'b1; end
            D_BSA: begin x_c[B_PC] = 1'b1; wr_c = 1'b1; inc_c[R_AR] = 1'b1; end
            default: sc_clr = 1'b1;
          endcase
        end
        5: begin
          case (d_q)
            D_AND: begin alu_c = ALU_AND_DR;  ld_c[R_AC] = 1'b1; sc_clr = 1'b1; end
            D_ADD: begin alu_c = ALU_ADD_DR;  ld_c[R_AC] = 1'b1; sc_clr = 1'b1; end
            D_LDA: begin alu_c = ALU_PASS_DR; ld_c[R_AC] = 1'b1; sc_clr = 1'b1; end
            D_BSA: begin x_c[B_AR] = 1'b1; ld_c[R_PC] = 1'b1; sc_clr = 1'b1; end
            D_ISZ: inc_c[R_DR] = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        6: begin
          sc_clr = 1'b1;
          // dr_zero reflects DR after the T5 increment.
          if (d_q == D_ISZ) begin
            x_c[B_DR] = 1'b1; wr_c = 1'b1; inc_c[R_PC] = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

  // Reset masks every output at once so no partial write can complete.
  assign x         = reset ? x_c   : '0;
  assign ld        = reset ? ld_c  : '0;
  assign inc       = reset ? inc_c : '0;
  assign clr       = reset ? clr_c : '0;
  assign mem_read  = reset & rd_c;
  assign mem_write = reset & wr_c;
  assign alu_op    = reset ? alu_c : '0;
  assign sc        = reset ? sc_q  : '0;
  assign halted    = reset & (mode == M_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected micro-step lists
// built from the instruction-set rules, checked every cycle by one compare process.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ir = '0;
  logic        ac_neg = 1'b0, ac_zero = 1'b0, dr_zero = 1'b0;
  logic [7:0]  x;
  logic [5:0]  ld, inc, clr;
  logic        mem_read, mem_write, halted;
  logic [1:0]  alu_op;
  logic [3:0]  sc;
`ifdef CU_SINGLE_STEP_EN
  logic step = 1'b0;
  localparam int SS = 1;
`else
  localparam int SS = 0;
`endif

  always #5 clk = ~clk;

  control_unit dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CU_SINGLE_STEP_EN
    .step      (step),
`endif
    .ir        (ir),
    .ac_neg    (ac_neg),
    .ac_zero   (ac_zero),
    .dr_zero   (dr_zero),
    .x         (x),
    .ld        (ld),
    .inc       (inc),
    .clr       (clr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .alu_op    (alu_op),
    .sc        (sc),
    .halted    (halted)
  );

  typedef struct packed {
    logic [3:0] sc;
    logic [7:0] x;
    logic [5:0] ld;
    logic [5:0] inc;
    logic [5:0] clr;
    logic       rd;
    logic       wr;
    logic [1:0] alu;
    logic       alu_care;
    logic       halted;
    logic       step;
  } exp_t;

  localparam int AR = 0, PC = 1, DR = 2, AC = 3, IRG = 4;
  localparam int S_NONE = 0, S_AR = 1, S_PC = 2, S_DR = 3, S_AC = 4, S_IR = 5, S_MEM = 7;

  exp_t exp_q[$];
  exp_t prog[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 0;

  function automatic logic [5:0] m(int r);
    return 6'(1 << r);
  endfunction

  function automatic exp_t rec(int t, int src, logic [5:0] l, logic [5:0] i, logic [5:0] c,
                               logic rd, logic wr, logic [1:0] alu, logic care);
    exp_t r;
    r = '0;
    r.sc = 4'(t);
    r.x = (src > 0) ? 8'(1 << src) : 8'h00;
    r.ld = l; r.inc = i; r.clr = c;
    r.rd = rd; r.wr = wr; r.alu = alu; r.alu_care = care;
    return r;
  endfunction

  function automatic exp_t idle_rec(logic h);
    exp_t r;
    r = '0;
    r.halted = h;
    return r;
  endfunction

  // Builds the expected cycle list for one instruction; returns 1 when it halts.
  function automatic bit build_prog(logic [15:0] irv, logic an, logic az, logic dz);
    logic       i;
    logic [2:0] d;
    int         top;
    bit         hlt;
    exp_t       r;
    hlt = 0;
    i = irv[15];
    d = irv[14:12];
    prog.delete();
    if (SS != 0) begin
      r = idle_rec(1'b0);
      r.step = 1'b1;
      prog.push_back(r);
    end
    prog.push_back(rec(0, S_PC, m(AR), 0, 0, 0, 0, 0, 0));
    prog.push_back(rec(1, S_MEM, m(IRG), m(PC), 0, 1, 0, 0, 0));
    prog.push_back(rec(2, S_IR, m(AR), 0, 0, 0, 0, 0, 0));
    if (d == 3'd7) begin
      top = -1;
      for (int b = 11; b >= 0; b--) if (top < 0 && irv[b]) top = b;
      r = rec(3, S_NONE, 0, 0, 0, 0, 0, 0, 0);
      if (!i) begin
        case (top)
          11: r.clr = m(AC);
          9:  begin r.ld = m(AC); r.alu = 2'd3; r.alu_care = 1'b1; end
          5:  r.inc = m(AC);
          4:  r.inc = an ? 6'h00 : m(PC);
          3:  r.inc = an ? m(PC) : 6'h00;
          2:  r.inc = az ? m(PC) : 6'h00;
          0:  hlt = 1;
          default: ;
        endcase
      end
      prog.push_back(r);
    end else begin
      if (i) prog.push_back(rec(3, S_MEM, m(AR), 0, 0, 1, 0, 0, 0));
      else   prog.push_back(rec(3, S_NONE, 0, 0, 0, 0, 0, 0, 0));
      case (d)
        3'd0, 3'd1, 3'd2: begin
          prog.push_back(rec(4, S_MEM, m(DR), 0, 0, 1, 0, 0, 0));
          prog.push_back(rec(5, S_NONE, m(AC), 0, 0, 0, 0,
                             (d == 3'd0) ? 2'd1 : (d == 3'd1) ? 2'd2 : 2'd0, 1));
        end
        3'd3: prog.push_back(rec(4, S_AC, 0, 0, 0, 0, 1, 0, 0));
        3'd4: prog.push_back(rec(4, S_AR, m(PC), 0, 0, 0, 0, 0, 0));
        3'd5: begin
          prog.push_back(rec(4, S_PC, 0, m(AR), 0, 0, 1, 0, 0));
          prog.push_back(rec(5, S_AR, m(PC), 0, 0, 0, 0, 0, 0));
        end
        default: begin
          prog.push_back(rec(4, S_MEM, m(DR), 0, 0, 1, 0, 0, 0));
          prog.push_back(rec(5, S_NONE, 0, m(DR), 0, 0, 0, 0, 0));
          prog.push_back(rec(6, S_DR, 0, dz ? m(PC) : 6'h00, 0, 0, 1, 0, 0));
        end
      endcase
    end
    return hlt;
  endfunction

  // Single compare process: one expected record per cycle, sampled at negedge.
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '0;
      a.sc = sc; a.x = x; a.ld = ld; a.inc = inc; a.clr = clr;
      a.rd = mem_read; a.wr = mem_write;
      a.alu = e.alu_care ? alu_op : 2'd0;
      a.alu_care = e.alu_care; a.halted = halted; a.step = e.step;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle t=%0t sc %0d/%0d x %h/%h ld %h/%h inc %h/%h clr %h/%h rd %b/%b wr %b/%b alu %0d/%0d halted %b/%b (actual/required)",
                 $time, a.sc, e.sc, a.x, e.x, a.ld, e.ld, a.inc, e.inc, a.clr, e.clr,
                 a.rd, e.rd, a.wr, e.wr, a.alu, e.alu, a.halted, e.halted);
      end
    end else if (started) begin
      tests++;
      fails++;
      $display("FAIL underflow t=%0t actual=empty required=record", $time);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_prog(logic [15:0] irv, logic an, logic az, logic dz, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      ir = (k <= SS) ? 16'($urandom) : irv;
      ac_neg = an; ac_zero = az; dr_zero = dz;
`ifdef CU_SINGLE_STEP_EN
      step = prog[k].step;
`endif
      exp_q.push_back(prog[k]);
      started = 1;
    end
  endtask

  task automatic idle_cycles(int n, logic h, logic rst_low);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rst_low) reset = 1'b0;
`ifdef CU_SINGLE_STEP_EN
      step = 1'b0;
`endif
      ir = 16'($urandom);
      exp_q.push_back(idle_rec(h));
      started = 1;
    end
  endtask

  task automatic run_instr(logic [15:0] irv, logic an, logic az, logic dz);
    bit hlt;
    hlt = build_prog(irv, an, az, dz);
    drive_prog(irv, an, az, dz, prog.size());
    if (hlt) idle_cycles(10, 1'b1, 1'b0);
  endtask

  function automatic logic [11:0] rr_field();
    int tops[6] = '{11, 9, 5, 4, 3, 2};
    int t;
    if ($urandom_range(0, 9) == 0) return 12'h000;
    t = tops[$urandom_range(0, 5)];
    return 12'((1 << t) | ($urandom & ((1 << t) - 1)));
  endfunction

  initial begin
    bit h;
    idle_cycles(2, 1'b0, 1'b1);

    // Pin the model against hand-computed micro-steps.
    h = build_prog(16'h2005, 0, 0, 0);
    chk("lda_len", prog.size(), 6 + SS);
    chk("lda_t0", {prog[SS].x, 2'b0, prog[SS].ld}, {8'h04, 8'h01});
    chk("lda_t1", {prog[SS+1].x, prog[SS+1].ld, prog[SS+1].inc, prog[SS+1].rd}, {8'h80, 6'h10, 6'h02, 1'b1});
    chk("lda_t4", {prog[SS+4].x, 2'b0, prog[SS+4].ld}, {8'h80, 8'h04});
    chk("lda_t5", {prog[SS+5].alu, prog[SS+5].ld}, {2'd0, 6'h08});
    run_instr(16'h2005, 0, 0, 0);

    h = build_prog(16'h9010, 0, 0, 0);
    chk("add_ind_t3", {prog[SS+3].x, prog[SS+3].rd, prog[SS+3].ld}, {8'h80, 1'b1, 6'h01});
    chk("add_ind_t5", {prog[SS+5].alu, prog[SS+5].ld}, {2'd2, 6'h08});
    run_instr(16'h9010, 0, 0, 0);

    h = build_prog(16'h6020, 0, 0, 1);
    chk("isz_t5", prog[SS+5].inc, 6'h04);
    chk("isz_t6_dz1", {prog[SS+6].x, prog[SS+6].wr, prog[SS+6].inc}, {8'h08, 1'b1, 6'h02});
    run_instr(16'h6020, 0, 0, 1);
    h = build_prog(16'h6020, 0, 0, 0);
    chk("isz_t6_dz0", prog[SS+6].inc, 6'h00);
    run_instr(16'h6020, 0, 0, 0);

    h = build_prog(16'h7004, 0, 1, 0);
    chk("sza_t3", prog[SS+3].inc, 6'h02);
    run_instr(16'h7004, 0, 1, 0);
    h = build_prog(16'h7A00, 0, 0, 0);
    chk("cla_cma_t3", {prog[SS+3].clr, prog[SS+3].ld}, {6'h08, 6'h00});
    run_instr(16'h7A00, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic       iv;
      logic [2:0] dv;
      logic [11:0] lo;
      iv = 1'($urandom_range(0, 1));
      dv = 3'($urandom_range(0, 7));
      lo = (dv == 3'd7 && !iv) ? rr_field() : 12'($urandom);
      run_instr({iv, dv, lo}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    // Reset in the middle of BSA T4 while mem_write is asserted.
    h = build_prog(16'h5123, 0, 0, 0);
    drive_prog(16'h5123, 0, 0, 0, SS + 5);
    @(negedge clk);
    #1;
    chk("bsa_t4_wr", mem_write, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_wr", mem_write, 1'b0);
    chk("rst_bus", {x, sc}, 12'h000);
    chk("rst_strobes", {ld, inc, clr, mem_read}, 19'h0);
    idle_cycles(1, 1'b0, 1'b1);
    run_instr(16'h3045, 0, 0, 0);

    run_instr(16'h7001, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("halt_flag", halted, 1'b1);
    chk("halt_quiet", {x, ld, inc, clr, sc}, 34'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired control unit for the 16-bit accumulator CPU; fills the empty control slot beside the bus mux, memory, encoder and registers.
- Consumes IR, AC status and DR status, and runs a 4-bit sequence counter (SC).
- Produces the one-hot bus-source vector x for the encoder, per-register load/increment/clear strobes, memory read/write and the AC ALU op.
- Sequences fetch, decode, and execute for memory-reference and register-reference instructions.

Parameters:
- SC_W, 4, sequence-counter width; T-states T0..T(2^SC_W-1).
- ADDR_W, 12, address field width taken from ir[ADDR_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ir  in  16  instruction register contents.
- ac_neg  in  1  ac[15].
- ac_zero  in  1  AC == 0.
- dr_zero  in  1  DR == 0. The CPU computes this combinationally from the DR output.
- x  out  8  one-hot bus source: bit1 AR, bit2 PC, bit3 DR, bit4 AC, bit5 IR, bit6 TR, bit7 MEM. All-zero means the bus is idle.
- ld  out  6  load strobes; index 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR.
- inc  out  6  increment strobes, same indexing as ld.
- clr  out  6  clear strobes, same indexing as ld.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write at AR, data taken from the bus.
- alu_op  out  2  AC input select: 0 PASS_DR, 1 AND_DR, 2 ADD_DR, 3 CMP_AC.
- sc  out  SC_W  current T-state.
- halted  out  1  HLT executed.

Behaviour:
- Reset (reset low, async):
  - sc=0, halted=0, latched I=0, latched D=0.
  - All outputs are forced 0 while reset is low, including mid-instruction; no partial write completes.
- Outputs are combinational from sc, the latched I/D, ir and the flags. Strobes take effect at the next clk edge.
- Exactly one bit of x is set in any cycle that drives the bus.
- sc increments each cycle unless a step clears it (sc←0 on the next edge).
- Fetch:
  - T0: x=PC, ld[AR].
  - T1: x=MEM, mem_read, ld[IR], inc[PC].
  - T2: x=IR, ld[AR]; latch I=ir[15], D=ir[14:12].
- T3:
  - D=7, I=0: register reference, then sc←0.
  - D=7, I=1: I/O, treated as NOP; sc←0.
  - D≠7, I=1: x=MEM, mem_read, ld[AR] (indirect).
  - D≠7, I=0: idle.
- Memory reference, T4 onward:
  - AND (D=0): T4 x=MEM, mem_read, ld[DR]; T5 alu_op=1, ld[AC], sc←0.
  - ADD (D=1): same as AND with alu_op=2; the carry is discarded.
  - LDA (D=2): as AND with alu_op=0.
  - STA (D=3): T4 x=AC, mem_write, sc←0.
  - BUN (D=4): T4 x=AR, ld[PC], sc←0.
  - BSA (D=5): T4 x=PC, mem_write, inc[AR]; T5 x=AR, ld[PC], sc←0.
  - ISZ (D=6): T4 x=MEM, mem_read, ld[DR]; T5 inc[DR]; T6 x=DR, mem_write, inc[PC] if dr_zero, sc←0. dr_zero is sampled in T6, after the DR increment.
- Register reference, executed in T3. Only the highest set bit of ir[11:0] acts; others are ignored.
  - bit11 CLA: clr[AC].
  - bit9 CMA: alu_op=3, ld[AC].
  - bit5 INC: inc[AC].
  - bit4 SPA: inc[PC] if !ac_neg.
  - bit3 SNA: inc[PC] if ac_neg.
  - bit2 SZA: inc[PC] if ac_zero.
  - bit0 HLT: halted←1.
  - No recognised bit set: NOP.
- Halt: halted stays 1, sc holds 0, and all strobes and x stay 0 until reset.
- sc never exceeds 6 under legal decode. If sc reaches an undefined state it returns to 0 on the next edge with no strobes.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - After each instruction-ending sc←0, the unit enters WAIT: sc=0, all outputs 0.
  - It leaves WAIT on the first edge where step=1 and T0 begins in the following cycle.
  - A step that is held high advances one instruction per rising transition only (edge detected internally).
  - Reset returns the unit to WAIT.
- Undefined: no step port; instructions run back-to-back; out of reset T0 begins immediately.

Decomposition:
- Package cpu_pkg holds:
  - Register index constants (AR..TR = 0..5) and bus-source bit positions (1..7).
  - Opcode constants for D = 0..7.
  - alu_op encodings.
  - Register-reference bit positions.
  - The TSTATE width.
- One sub-module, seq_counter: SC_W-bit counter with async active-low reset, synchronous clear, and hold (used for halt and wait).

Test Plan:
- LDA direct: ir=0x2005 presented from T1.
  - T0: x=0x04, ld=0x01.
  - T1: x=0x80, ld=0x10, inc=0x02, mem_read=1.
  - T2: x=0x20, ld=0x01.
  - T3: idle.
  - T4: x=0x80, ld=0x04.
  - T5: alu_op=0, ld=0x08.
  - sc=0 at cycle 6.
- ADD indirect: ir=0x9010.
  - T3: x=0x80, mem_read=1, ld=0x01.
  - T5: alu_op=2, ld=0x08.
  - Total 6 cycles.
- ISZ with dr_zero=1 in T6: ir=0x6020.
  - T5: inc=0x04.
  - T6: x=0x08, mem_write=1, inc=0x02.
  - Repeat with dr_zero=0: inc=0x00 in T6.
- Register reference: ir=0x7004 with ac_zero=1 gives T3 inc=0x02. ir=0x7A00 (CLA+CMA) gives clr=0x08 only.
- HLT: ir=0x7001 gives halted=1 after T3. For 10 further cycles: sc=0, x=0, ld=inc=clr=0.
- Reset asserted during BSA T4 (mem_write=1):
  - Outputs go to 0 immediately and sc=0.
  - After release, T0 fetch restarts (with CU_SINGLE_STEP_EN, WAIT until a step pulse).
